// File: rtl/raw2rgb_demosaic.sv
// raw2rgb_demosaic: Bayer-to-RGB converter built on a 2x2 window.
// The window is formed from a one-line buffer (row above) and the current row.
// Output is either one RGB pixel per input pixel or one per Bayer quad, with
// the bottom-right window coordinate carried alongside the colour data.
`timescale 1ns/1ps

module raw2rgb_demosaic #(
  parameter int DATA_W     = 10,
  parameter int X_W        = 11,
  parameter int Y_W        = 11,
  parameter int LINE_W     = 1280,
  parameter int BAYER_MODE = 0,
  parameter int DECIMATE   = 0
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic [X_W-1:0]    iX_Cont,
  input  logic [Y_W-1:0]    iY_Cont,
  output logic [DATA_W-1:0] oRed,
  output logic [DATA_W-1:0] oGreen,
  output logic [DATA_W-1:0] oBlue,
  output logic              oDVAL,
  output logic [X_W-1:0]    oX_Cont,
  output logic [Y_W-1:0]    oY_Cont
);

  // Bayer phase of pixel (0,0) as {py,px}; XOR with coordinate LSBs gives the
  // colour layout of the current window.
  localparam logic [1:0]  PHASE0   = 2'(BAYER_MODE);
  localparam logic [31:0] LINE_LIM = 32'(LINE_W);
  localparam bit          DEC      = (DECIMATE != 0);

  // Line buffer holding the previous row; deliberately never reset.
  logic [DATA_W-1:0] line_buf [LINE_W];

  // Stage-1 window and its coordinate/qualifier.
  logic [DATA_W-1:0] up;
  logic [DATA_W-1:0] up_l;
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] cur_l;
  logic [X_W-1:0]    x_s1;
  logic [Y_W-1:0]    y_s1;
  logic              acc_s1;
  logic [1:0]        rows_seen;

  // Colour selection from the window.
  logic              accept;
  logic [1:0]        phase;
  logic [DATA_W-1:0] red_sel;
  logic [DATA_W-1:0] blue_sel;
  logic [DATA_W-1:0] green_a;
  logic [DATA_W-1:0] green_b;
  logic [DATA_W:0]   green_sum;
  logic              out_en;
  logic [X_W-1:0]    out_x;
  logic [Y_W-1:0]    out_y;

  // Pixels beyond the line-buffer depth are dropped entirely.
  assign accept = iDVAL && (32'(iX_Cont) < LINE_LIM);

  // Line-buffer write; the window read of the same address sees the old data.
  always_ff @(posedge iCLK) begin
    if (accept && !iRST) begin
      line_buf[iX_Cont] <= iDATA;
    end
  end

  // Window shift, coordinate capture and row-prime counting on accepted pixels.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      up        <= '0;
      up_l      <= '0;
      cur       <= '0;
      cur_l     <= '0;
      x_s1      <= '0;
      y_s1      <= '0;
      acc_s1    <= 1'b0;
      rows_seen <= 2'd0;
    end else begin
      acc_s1 <= accept;
      if (accept) begin
        up    <= line_buf[iX_Cont];
        cur   <= iDATA;
        up_l  <= up;
        cur_l <= cur;
        x_s1  <= iX_Cont;
        y_s1  <= iY_Cont;
        if ((iX_Cont == '0) && (rows_seen != 2'd2)) begin
          rows_seen <= rows_seen + 2'd1;
        end
      end
    end
  end

  assign phase = {y_s1[0] ^ PHASE0[1], x_s1[0] ^ PHASE0[0]};

  // Pick red, blue and the two greens according to where red sits in the window.
  always_comb begin
    red_sel  = cur;
    blue_sel = up_l;
    green_a  = up;
    green_b  = cur_l;
    case (phase)
      2'b00: begin
        red_sel  = cur;
        blue_sel = up_l;
        green_a  = up;
        green_b  = cur_l;
      end
      2'b01: begin
        red_sel  = cur_l;
        blue_sel = up;
        green_a  = cur;
        green_b  = up_l;
      end
      2'b10: begin
        red_sel  = up;
        blue_sel = cur_l;
        green_a  = cur;
        green_b  = up_l;
      end
      default: begin
        red_sel  = up_l;
        blue_sel = cur;
        green_a  = up;
        green_b  = cur_l;
      end
    endcase
  end

  // One extra bit keeps the green sum from wrapping before the halving.
  assign green_sum = {1'b0, green_a} + {1'b0, green_b};

  // A window is complete only off row 0 / column 0 and once a full row
  // written since reset sits in the line buffer.
  assign out_en = acc_s1 && (x_s1 != '0) && (y_s1 != '0) && (rows_seen == 2'd2) &&
                  (!DEC || (x_s1[0] && y_s1[0]));

  assign out_x = DEC ? (x_s1 >> 1) : x_s1;
  assign out_y = DEC ? (y_s1 >> 1) : y_s1;

  // Output register: values hold between valid pixels.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oRed    <= '0;
      oGreen  <= '0;
      oBlue   <= '0;
      oDVAL   <= 1'b0;
      oX_Cont <= '0;
      oY_Cont <= '0;
    end else begin
      oDVAL <= out_en;
      if (out_en) begin
        oRed    <= red_sel;
        oGreen  <= green_sum[DATA_W:1];
        oBlue   <= blue_sel;
        oX_Cont <= out_x;
        oY_Cont <= out_y;
      end
    end
  end

endmodule

// File: doc/raw2rgb_demosaic.md
Name: raw2rgb_demosaic

Overview:
Parametrised Bayer-to-RGB converter for the CCD capture path. It sits between the sensor capture and coordinate-counter logic and the frame-buffer writer or filter chain. It builds a 2x2 window from an internal one-line buffer and can emit either one RGB pixel per input pixel (full resolution) or one per Bayer quad (decimated, legacy half-resolution behaviour). The Bayer phase is selectable, and output coordinates travel with the data.

Parameters:
DATA_W, 10, raw and per-channel RGB width in bits
X_W, 11, width of the X coordinate
Y_W, 11, width of the Y coordinate
LINE_W, 1280, maximum pixels per line; sets the line-buffer depth
BAYER_MODE, 0, colour of pixel (0,0): 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR; encoded as {py,px}
DECIMATE, 0, 0 = full-resolution output; 1 = one output per 2x2 quad

Ports:
iCLK  in  1  clock; all logic on the rising edge
iRST  in  1  synchronous, active-high reset
iDATA  in  DATA_W  raw Bayer pixel
iDVAL  in  1  iDATA, iX_Cont and iY_Cont are valid this cycle
iX_Cont  in  X_W  column of iDATA
iY_Cont  in  Y_W  row of iDATA
oRed  out  DATA_W  red
oGreen  out  DATA_W  green (average of two greens)
oBlue  out  DATA_W  blue
oDVAL  out  1  RGB and coordinates valid; one-cycle qualifier
oX_Cont  out  X_W  output column
oY_Cont  out  Y_W  output row

Behaviour:
- Reset:
  - Takes effect on the iCLK edge where iRST=1.
  - oRed, oGreen, oBlue, oDVAL, oX_Cont and oY_Cont go to 0.
  - Window registers and the row-prime counter clear.
  - Line-buffer RAM is not cleared.
- Stage 1, on an iDVAL cycle with iX_Cont < LINE_W:
  - up <= lb[x], using read-before-write (old-data) semantics.
  - lb[x] <= iDATA.
  - cur <= iDATA.
  - up_l <= previous up; cur_l <= previous cur.
  - x, y and the accept bit are registered alongside.
- Pixels with iX_Cont >= LINE_W are ignored: no write, no output.
- Cycles with iDVAL=0 do not advance the window registers.
- Stage 2 is the output register. Latency is exactly 2 cycles: an iDVAL at cycle N gives oDVAL at cycle N+2.
- Window is {up_l, up; cur_l, cur}. The bottom-right pixel is at (x,y).
- Phase = {y[0]^py, x[0]^px}:
  - 00: R=cur, B=up_l, Gsum=up+cur_l
  - 01: R=cur_l, B=up, Gsum=cur+up_l
  - 10: R=up, B=cur_l, Gsum=cur+up_l
  - 11: R=up_l, B=cur, Gsum=up+cur_l
- Gsum is DATA_W+1 bits with no overflow. oGreen = Gsum[DATA_W:1] (truncating average).
- Output enable, all conditions required:
  - the pixel was accepted;
  - x >= 1 and y >= 1;
  - rows_seen == 2.
  - With DECIMATE=1, additionally x[0]=1 and y[0]=1.
- rows_seen is a 2-bit saturating counter. It increments on each accepted pixel with x==0. This suppresses output until the second row started after reset, so stale line-buffer data is never emitted.
- Output coordinates:
  - DECIMATE=0: oX_Cont = x, oY_Cont = y.
  - DECIMATE=1: oX_Cont = x>>1, oY_Cont = y>>1.
- When oDVAL=0, oRed, oGreen, oBlue and the coordinates hold their last values.
- Row y=0 of every frame and column x=0 of every row produce no output.
- Back-to-back frames need no idle gap. Row 0 of a new frame is suppressed by the y >= 1 rule.
- Reset mid-frame:
  - Outputs zero on the next edge.
  - In-flight pixels are discarded, with no oDVAL for them.
  - After release, output resumes only from the second row start.

Test Plan:
1. Reset with iRST=1 while iDVAL=1 -> next cycle all outputs 0, oDVAL=0. Hold iRST=1 for 3 cycles -> outputs remain 0.
2. RGGB, DECIMATE=0, 4x4 frame, pixel value = 16*y+x, after a priming row → at (1,1): R=0, B=17, G=(1+16)>>1=8; at (2,1): R=2, B=17, G=(1+18)>>1=9. oDVAL is asserted exactly 2 cycles after each accepted input and never for x=0 or y=0.
3. Same frame with DECIMATE=1 → outputs only at (1,1), (3,1), (1,3), (3,3). oX_Cont/oY_Cont are (0,0), (1,0), (0,1), (1,1). RGB values match scenario 2.
4. BAYER_MODE=3, all B pixels=1023 and all G pixels=1023 -> oBlue=1023 and oGreen=1023 (Gsum=2046, no wrap).
5. iDVAL de-asserted for 5 cycles mid-row → window is not corrupted; the next pixel's RGB equals the continuous-stream result. oDVAL=0 for the whole gap.
6. iX_Cont=LINE_W (1280) with iDVAL=1 → no oDVAL, and line-buffer contents at x<1280 are unchanged on the next row.
